// File: rtl/gcd_pkg.sv
// Shared types for the GCD requester: FSM state encoding and the operand-pair record
// carried through the request FIFO and the in-flight hold register.
package gcd_pkg;

  localparam int GCD_WL = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } gcd_state_e;

  typedef struct packed {
    logic [GCD_WL-1:0] a;
    logic [GCD_WL-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/gcd_requester_if.sv
// Host, GCD-unit and completion handshakes of the requester; master is the requester
// view, slave is the view of the logic surrounding it.
interface gcd_requester_if #(
  parameter int WL = 8
);
  logic          cmd_val;
  logic          cmd_rdy;
  logic [WL-1:0] cmd_a;
  logic [WL-1:0] cmd_b;
  logic          ops_val;
  logic          ops_rdy;
  logic [WL-1:0] ops_a;
  logic [WL-1:0] ops_b;
  logic          res_val;
  logic          res_rdy;
  logic [WL-1:0] res_data;
  logic          out_val;
  logic          out_rdy;
  logic [WL-1:0] out_a;
  logic [WL-1:0] out_b;
  logic [WL-1:0] out_gcd;

  modport master (
    input  cmd_val, cmd_a, cmd_b, ops_rdy, res_val, res_data, out_rdy,
    output cmd_rdy, ops_val, ops_a, ops_b, res_rdy, out_val, out_a, out_b, out_gcd
  );

  modport slave (
    output cmd_val, cmd_a, cmd_b, ops_rdy, res_val, res_data, out_rdy,
    input  cmd_rdy, ops_val, ops_a, ops_b, res_rdy, out_val, out_a, out_b, out_gcd
  );
endinterface

// File: rtl/gcd_req_fifo.sv
// Request FIFO of operand pairs. Full/empty come only from the registered pointers,
// so a pop never makes room for a push in the same cycle.
module gcd_req_fifo
  import gcd_pkg::*;
#(
  parameter int WL    = GCD_WL,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            push_i,
  input  logic [2*WL-1:0] wdata_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [2*WL-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  operand_pair_t mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage and pointers; the extra pointer bit separates full from empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= operand_pair_t'(wdata_i);
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/gcd_requester.sv
// Initiator for the GCD unit: queues host operand pairs, issues one at a time, and
// returns each result to the host together with the operands that produced it.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WL      = GCD_WL,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_b,
  gcd_requester_if.master    bus,
  output logic [COUNT_W-1:0] done_cnt
);
  gcd_state_e         state_q, state_d;
  operand_pair_t      hold_q, hold_d;
  logic [WL-1:0]      gcd_q, gcd_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [2*WL-1:0]    head_raw_s;
  operand_pair_t      head_s;
  logic               full_s;
  logic               empty_s;
  logic               pop_s;

  gcd_req_fifo #(
    .WL    (WL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (bus.cmd_val),
    .wdata_i ({bus.cmd_a, bus.cmd_b}),
    .pop_i   (pop_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .head_o  (head_raw_s)
  );

  assign head_s = operand_pair_t'(head_raw_s);

  // Next-state logic; the hold register captures the head as it is popped.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gcd_d   = gcd_q;
    cnt_d   = cnt_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) state_d = ISSUE;
        else          state_d = IDLE;
      end
      ISSUE: begin
        if (bus.ops_rdy) begin
          pop_s   = 1'b1;
          hold_d  = head_s;
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (bus.res_val) begin
          gcd_d   = bus.res_data;
          state_d = DELIVER;
        end else begin
          state_d = WAIT;
        end
      end
      DELIVER: begin
        if (bus.out_rdy) begin
          cnt_d   = cnt_q + COUNT_W'(1);
          state_d = empty_s ? IDLE : ISSUE;
        end else begin
          state_d = DELIVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, in-flight operands, latched result and completion counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gcd_q   <= gcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.cmd_rdy = !full_s;
  assign bus.ops_val = (state_q == ISSUE);
  assign bus.res_rdy = (state_q == WAIT);
  assign bus.out_val = (state_q == DELIVER);
  assign bus.ops_a   = head_s.a;
  assign bus.ops_b   = head_s.b;
  assign bus.out_a   = hold_q.a;
  assign bus.out_b   = hold_q.b;
  assign bus.out_gcd = gcd_q;
  assign done_cnt    = cnt_q;
endmodule

// File: tb/tb_gcd_requester.sv
// Directed and randomized checks of gcd_requester against a queue-based reference of
// accepted operand pairs, with Euclid's algorithm standing in for the GCD unit.
module tb_gcd_requester;
  localparam int WL = 8;
  localparam int CW = 4;

  typedef struct {
    logic [WL-1:0] a;
    logic [WL-1:0] b;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [CW-1:0] done_cnt;
  int            checks = 0;
  int            failures = 0;
  int            exp_cnt = 0;
  logic [WL-1:0] last_gcd = '0;
  pair_t         q[$];

  gcd_requester_if #(.WL(WL)) bus ();

  gcd_requester #(.WL(WL), .DEPTH(4), .COUNT_W(CW)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .bus      (bus),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WL-1:0] ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    while (y != 0) begin
      int t = x % y;
      x = y;
      y = t;
    end
    return WL'(x);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [WL-1:0] a, input logic [WL-1:0] b);
    int n = 0;
    bus.cmd_val = 1'b1;
    bus.cmd_a   = a;
    bus.cmd_b   = b;
    while (!bus.cmd_rdy && n < 100) begin
      step();
      n++;
    end
    check("push_rdy", 32'(bus.cmd_rdy), 32'd1);
    step();
    bus.cmd_val = 1'b0;
    q.push_back('{a, b});
  endtask

  task automatic issue_req(output pair_t e);
    int n = 0;
    while (!bus.ops_val && n < 50) begin
      step();
      n++;
    end
    check("ops_wait", 32'(bus.ops_val), 32'd1);
    e = (q.size() > 0) ? q.pop_front() : '{8'd0, 8'd0};
    check("ops_a", 32'(bus.ops_a), 32'(e.a));
    check("ops_b", 32'(bus.ops_b), 32'(e.b));
    bus.ops_rdy = 1'b1;
    step();
    bus.ops_rdy = 1'b0;
    check("issued_ops_val", 32'(bus.ops_val), 32'd0);
    check("issued_res_rdy", 32'(bus.res_rdy), 32'd1);
  endtask

  task automatic complete_req(input pair_t e, input int delay, input int stall);
    logic [WL-1:0] g;
    g = ref_gcd(int'(e.a), int'(e.b));
    repeat (delay) step();
    check("wait_res_rdy", 32'(bus.res_rdy), 32'd1);
    check("wait_out_val", 32'(bus.out_val), 32'd0);
    bus.res_val  = 1'b1;
    bus.res_data = g;
    step();
    bus.res_val  = 1'b0;
    check("out_val", 32'(bus.out_val), 32'd1);
    check("out_a", 32'(bus.out_a), 32'(e.a));
    check("out_b", 32'(bus.out_b), 32'(e.b));
    check("out_gcd", 32'(bus.out_gcd), 32'(g));
    check("deliver_res_rdy", 32'(bus.res_rdy), 32'd0);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_out_val", 32'(bus.out_val), 32'd1);
      check("stall_res_rdy", 32'(bus.res_rdy), 32'd0);
      check("stall_ops_val", 32'(bus.ops_val), 32'd0);
    end
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    exp_cnt  = (exp_cnt + 1) % (1 << CW);
    last_gcd = g;
    check("done_cnt", 32'(done_cnt), 32'(exp_cnt));
    check("post_out_val", 32'(bus.out_val), 32'd0);
    check("next_ops_val", 32'(bus.ops_val), (q.size() != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic serve(input int delay, input int stall);
    pair_t e;
    issue_req(e);
    complete_req(e, delay, stall);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 32'd1);
    check({tag, "_ops_val"}, 32'(bus.ops_val), 32'd0);
    check({tag, "_res_rdy"}, 32'(bus.res_rdy), 32'd0);
    check({tag, "_out_val"}, 32'(bus.out_val), 32'd0);
    check({tag, "_ops_a"}, 32'(bus.ops_a), 32'd0);
    check({tag, "_ops_b"}, 32'(bus.ops_b), 32'd0);
    check({tag, "_out_a"}, 32'(bus.out_a), 32'd0);
    check({tag, "_out_b"}, 32'(bus.out_b), 32'd0);
    check({tag, "_out_gcd"}, 32'(bus.out_gcd), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
  endtask

  initial begin
    pair_t p[5];
    pair_t e;
    bus.cmd_val = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.ops_rdy = 1'b0; bus.res_val = 1'b0; bus.res_data = '0; bus.out_rdy = 1'b0;

    // Reset state
    repeat (3) step();
    check_reset_values("reset");
    rst_b = 1'b1;
    step();

    // Single request: ops_val two cycles after the cmd handshake, result 4
    push(8'd12, 8'd8);
    check("lat_t1_ops_val", 32'(bus.ops_val), 32'd0);
    step();
    check("lat_t2_ops_val", 32'(bus.ops_val), 32'd1);
    serve(5, 0);
    check("single_gcd", 32'(last_gcd), 32'd4);
    step();
    check("single_idle_ops_val", 32'(bus.ops_val), 32'd0);

    // Operand stability under ops backpressure
    push(8'd35, 8'd21);
    step();
    for (int i = 0; i < 10; i++) begin
      check("stable_ops_val", 32'(bus.ops_val), 32'd1);
      check("stable_ops_a", 32'(bus.ops_a), 32'd35);
      check("stable_ops_b", 32'(bus.ops_b), 32'd21);
      step();
    end
    serve(1, 0);
    check("stable_gcd", 32'(last_gcd), 32'd7);

    // FIFO full: a pop does not free space for a push in the same cycle
    for (int i = 0; i < 5; i++) begin
      p[i].a = WL'($urandom_range(255, 1));
      p[i].b = WL'($urandom_range(255, 1));
    end
    for (int i = 0; i < 4; i++) push(p[i].a, p[i].b);
    check("full_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    bus.cmd_val = 1'b1; bus.cmd_a = p[4].a; bus.cmd_b = p[4].b;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_hold_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      check("full_hold_ops_val", 32'(bus.ops_val), 32'd1);
    end
    check("full_head_a", 32'(bus.ops_a), 32'(p[0].a));
    check("full_head_b", 32'(bus.ops_b), 32'(p[0].b));
    bus.ops_rdy = 1'b1;
    step();
    bus.ops_rdy = 1'b0;
    e = q.pop_front();
    check("pop_no_push_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    check("pop_ops_val", 32'(bus.ops_val), 32'd0);
    step();
    bus.cmd_val = 1'b0;
    q.push_back(p[4]);
    check("late_push_full", 32'(bus.cmd_rdy), 32'd0);
    complete_req(e, 2, 0);
    for (int i = 0; i < 4; i++) serve($urandom_range(3, 0), 0);

    // Out backpressure and ordering
    push(8'd48, 8'd18);
    push(8'd7, 8'd5);
    push(8'd100, 8'd75);
    serve(2, 8);
    check("order_gcd0", 32'(last_gcd), 32'd6);
    serve(1, 0);
    check("order_gcd1", 32'(last_gcd), 32'd1);
    serve(3, 0);
    check("order_gcd2", 32'(last_gcd), 32'd25);

    // Spurious results in IDLE and ISSUE are ignored
    step();
    bus.res_val = 1'b1; bus.res_data = 8'hAA;
    step();
    bus.res_val = 1'b0;
    check("spur_idle_res_rdy", 32'(bus.res_rdy), 32'd0);
    check("spur_idle_out_val", 32'(bus.out_val), 32'd0);
    check("spur_idle_gcd", 32'(bus.out_gcd), 32'(last_gcd));
    push(8'd9, 8'd6);
    step();
    check("spur_issue_ops_val", 32'(bus.ops_val), 32'd1);
    bus.res_val = 1'b1; bus.res_data = 8'h55;
    step();
    bus.res_val = 1'b0;
    check("spur_issue_res_rdy", 32'(bus.res_rdy), 32'd0);
    check("spur_issue_ops_val2", 32'(bus.ops_val), 32'd1);
    check("spur_issue_gcd", 32'(bus.out_gcd), 32'(last_gcd));
    serve(0, 0);
    check("spur_gcd", 32'(last_gcd), 32'd3);

    // Reset in WAIT with two entries queued
    push(8'd20, 8'd15);
    push(8'd33, 8'd22);
    push(8'd81, 8'd27);
    issue_req(e);
    step();
    #1 rst_b = 1'b0;
    #1;
    check_reset_values("midrst");
    step();
    rst_b = 1'b1;
    q.delete();
    exp_cnt  = 0;
    last_gcd = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("postrst_ops_val", 32'(bus.ops_val), 32'd0);
      check("postrst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    end

    // Counter wrap with a 4-bit counter and random operands
    for (int i = 1; i <= 16; i++) begin
      push(WL'($urandom_range(255, 1)), WL'($urandom_range(255, 1)));
      serve($urandom_range(3, 0), $urandom_range(2, 0));
      if (i == 15) check("wrap_15", 32'(done_cnt), 32'd15);
      if (i == 16) check("wrap_16", 32'(done_cnt), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
